// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt block: register map, decode width,
// parameter bounds and the bus request payload.
package gpio_pkg;

  localparam int unsigned BUS_W       = 32;
  localparam int unsigned ADDR_LSB    = 2;
  localparam int unsigned ADDR_DEC_W  = 3;

  localparam logic [ADDR_DEC_W-1:0] REG_GPEN       = 3'd0;
  localparam logic [ADDR_DEC_W-1:0] REG_GPO        = 3'd1;
  localparam logic [ADDR_DEC_W-1:0] REG_GPI        = 3'd2;
  localparam logic [ADDR_DEC_W-1:0] REG_GPO_SET    = 3'd3;
  localparam logic [ADDR_DEC_W-1:0] REG_GPO_CLR    = 3'd4;
  localparam logic [ADDR_DEC_W-1:0] REG_RISE_EN    = 3'd5;
  localparam logic [ADDR_DEC_W-1:0] REG_FALL_EN    = 3'd6;
  localparam logic [ADDR_DEC_W-1:0] REG_IRQ_STATUS = 3'd7;

  localparam int unsigned GPIO_WIDTH_MIN      = 1;
  localparam int unsigned GPIO_WIDTH_MAX      = 32;
  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned SYNC_STAGES_MAX     = 4;
  localparam int unsigned DEBOUNCE_CYCLES_MIN = 2;
  localparam int unsigned DEBOUNCE_CYCLES_MAX = 65535;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [ADDR_DEC_W-1:0] sel;
    logic [BUS_W-1:0]      wdata;
  } bus_req_t;

  function automatic bit in_range(input int unsigned v, input int unsigned lo,
                                  input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// Per-pin input conditioning: synchroniser, optional debounce filter and edge
// detect. Debounce is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic filt_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   filt;
  logic                   sync_out;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_out;
`endif

  always_comb begin
    prev_d = filt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign filt_o   = filt;
  assign rise_c_o = filt & ~prev_q;
  assign fall_c_o = ~filt & prev_q;

endmodule

// File: rtl/gpio_irq.sv
// GPIO block with per-pin output enable/value, filtered inputs and edge
// interrupts. Define GPIO_DEBOUNCE_EN to add the per-pin debounce filter.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH      = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [31:0]           addr,
  input  logic [31:0]           data,
  input  logic                  we,
  output logic [31:0]           q,
  input  logic [GPIO_WIDTH-1:0] gpi,
  output logic [GPIO_WIDTH-1:0] gpen,
  output logic [GPIO_WIDTH-1:0] gpo,
  output logic                  irq
);

  localparam bit PARAMS_OK =
      in_range(GPIO_WIDTH, GPIO_WIDTH_MIN, GPIO_WIDTH_MAX) &&
      in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX) &&
      in_range(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES_MIN, DEBOUNCE_CYCLES_MAX);

  if (!PARAMS_OK) begin : g_bad_params
    $error("gpio_irq: parameter out of legal range");
  end

  bus_req_t              req;
  logic                  accept_c;
  logic                  wr_c;
  logic [GPIO_WIDTH-1:0] wdata;
  logic                  unused_bus_bits;

  logic                  mem_ready_q, mem_ready_d;
  logic [GPIO_WIDTH-1:0] gpen_q, gpen_d;
  logic [GPIO_WIDTH-1:0] gpo_q, gpo_d;
  logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [GPIO_WIDTH-1:0] status_q, status_d;
  logic                  irq_q, irq_d;

  logic [GPIO_WIDTH-1:0] filt;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [GPIO_WIDTH-1:0] set_c;
  logic [GPIO_WIDTH-1:0] clr_c;
  logic [31:0]           rdata;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    gpio_in_cond #(
      .SYNC_STAGES    (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
    ) u_cond (
      .clk     (clk),
      .reset   (reset),
      .pin_i   (gpi[i]),
      .filt_o  (filt[i]),
      .rise_c_o(rise[i]),
      .fall_c_o(fall[i])
    );
  end

  always_comb begin
    req.valid = mem_valid;
    req.we    = we;
    req.sel   = addr[ADDR_LSB +: ADDR_DEC_W];
    req.wdata = data;
  end

  assign unused_bus_bits = ^{addr[31:ADDR_LSB+ADDR_DEC_W], addr[ADDR_LSB-1:0], req.wdata};

  // An access is taken only while no completion pulse is outstanding.
  assign accept_c = req.valid & ~mem_ready_q;
  assign wr_c     = accept_c & req.we;
  assign wdata    = req.wdata[GPIO_WIDTH-1:0];
  assign set_c    = (rise & rise_en_q) | (fall & fall_en_q);

  always_comb begin
    mem_ready_d = accept_c;
    gpen_d      = gpen_q;
    gpo_d       = gpo_q;
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    clr_c       = '0;
    if (wr_c) begin
      case (req.sel)
        REG_GPEN:       gpen_d    = wdata;
        REG_GPO:        gpo_d     = wdata;
        REG_GPO_SET:    gpo_d     = gpo_q | wdata;
        REG_GPO_CLR:    gpo_d     = gpo_q & ~wdata;
        REG_RISE_EN:    rise_en_d = wdata;
        REG_FALL_EN:    fall_en_d = wdata;
        REG_IRQ_STATUS: clr_c     = wdata;
        default:        ;
      endcase
    end
    // A new edge wins over a same-cycle clear.
    status_d = (status_q & ~clr_c) | set_c;
    irq_d    = |status_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready_q <= 1'b0;
      gpen_q      <= '0;
      gpo_q       <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      status_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      mem_ready_q <= mem_ready_d;
      gpen_q      <= gpen_d;
      gpo_q       <= gpo_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      status_q    <= status_d;
      irq_q       <= irq_d;
    end
  end

  // Read data is combinational and zero whenever no access is presented.
  always_comb begin
    rdata = '0;
    if (req.valid) begin
      case (req.sel)
        REG_GPEN:       rdata = 32'(gpen_q);
        REG_GPO:        rdata = 32'(gpo_q);
        REG_GPI:        rdata = 32'(filt);
        REG_RISE_EN:    rdata = 32'(rise_en_q);
        REG_FALL_EN:    rdata = 32'(fall_en_q);
        REG_IRQ_STATUS: rdata = 32'(status_q);
        default:        rdata = '0;
      endcase
    end
  end

  assign q         = rdata;
  assign mem_ready = mem_ready_q;
  assign gpen      = gpen_q;
  assign gpo       = gpo_q;
  assign irq       = irq_q;

endmodule
